mfsk_dds_mod: RTL and testbench
===============================

# mfsk_dds_mod

Parametrised M-ary FSK modulator: the phase-continuous successor of the two-tone FSK block, driving the same 8-bit-class parallel DAC. Accepts one symbol of BITS_PER_SYM bits per handshake and maps it to one of 2^BITS_PER_SYM tones (tone = base + sym·step). Generates the tone with a DDS phase accumulator and a selectable waveform. Drives da_data and da_clk at sys_clk/2. Sits behind the PLL in the FSK top level, on the 100 MHz domain.

## Interface
- DATA_W, 8: DAC sample width N (≥4)
- PHASE_W, 32: phase accumulator width (≥ DATA_W+2)
- BITS_PER_SYM, 2: K; the block provides M = 2^K tones
- SYM_SAMPLES, 1000: DAC samples per symbol (≥2)
- sys_clk  in  1  sole clock
- sys_rst  in  1  asynchronous, active-high reset
- en  in  1  enables symbol acceptance
- wave_sel  in  2  0 sine-approx, 1 triangle, 2 square, 3 sawtooth
- tone_base  in  PHASE_W  tuning word for symbol 0
- tone_step  in  PHASE_W  tuning-word increment per symbol value
- s_valid  in  1  symbol available
- s_sym  in  K  symbol value
- s_ready  out  1  symbol accepted on an edge where s_valid&&s_ready
- da_data  out  DATA_W  DAC sample, offset binary
- da_clk  out  1  DAC latch clock; DAC samples on its rising edge
- busy  out  1  high in RUN
- underrun  out  1  one-cycle pulse on data starvation

## Operation
- Toggle t: registered and toggles every cycle after reset. da_clk = t.
- Sample edge: a clock edge where t==1, i.e. da_clk falls. da_data, phase and the sample counter update only on sample edges.
- States:
  - IDLE: phase = 0, da_data = 2^(N-1) (midscale). s_ready = en.
  - RUN: on each sample edge:
    - da_data ← wave(phase), computed from the pre-increment phase.
    - phase ← phase + tone_word, modulo 2^PHASE_W.
    - samp_cnt ← samp_cnt + 1.
- Symbol load: on handshake, register both of:
  - tone_word ← tone_base + s_sym·tone_step, modulo 2^PHASE_W.
  - wave_r ← wave_sel.
  - wave_sel changes take effect only at symbol load.
- IDLE→RUN: on handshake in IDLE. samp_cnt ← 0; phase stays 0.
- s_ready in RUN: high only in a cycle where t==1 and samp_cnt==SYM_SAMPLES-1, i.e. the last sample edge of the symbol. Combinational from registers.
- Last sample edge with handshake:
  - New tone and wave loaded; samp_cnt ← 0.
  - Phase is not reset (phase-continuous).
  - The emitted sample still uses the old tone's phase.
- Last sample edge without handshake: the block goes to IDLE.
  - phase ← 0; da_data ← midscale (this replaces the final-sample update).
  - underrun pulses for 1 cycle only if en==1.
  - en==0 means a clean stop with no underrun.
- en deassert mid-symbol: the current symbol completes.
- Waveforms, with h = phase[PHASE_W-1] and r = phase[PHASE_W-2 -: N]:
  - sawtooth: phase[PHASE_W-1 -: N].
  - triangle: h ? ~r : r.
  - square: h ? 0 : 2^N-1.
  - sine-approx:
    - x = phase[PHASE_W-2 -: N+1].
    - q = x·(2^(N+1)-1-x), full width 2N+2.
    - mag = q >> (N+1), range 0..2^(N-1)-1.
    - output = h ? 2^(N-1)-mag : 2^(N-1)+mag.
- Reset (asynchronous, any time): all outputs and state return to reset values immediately, including mid-symbol.

## Timing
- Reset values: da_data = 2^(N-1), da_clk = 0, s_ready = 0 (en-dependent once released), busy = 0, underrun = 0, phase = 0, state IDLE.
- Sample period: 2 sys_clk cycles; da_data is stable around every da_clk rise.
- Latency from handshake in IDLE:
  - busy rises on the next edge.
  - The first RUN sample edge (phase 0) occurs within 2 cycles.
- Symbol duration: exactly SYM_SAMPLES sample edges, i.e. 2·SYM_SAMPLES cycles, gap-free under back-to-back handshakes.
- underrun is asserted for exactly 1 cycle, following the last sample edge.

## Test plan
Unless stated, PHASE_W=32, N=8, K=2, SYM_SAMPLES=4, tone_base=tone_step=0x1000_0000, wave_sel=3.

- Reset → da_data=0x80, da_clk=0, busy=0. da_clk then toggles every cycle while da_data holds 0x80.
- Phase continuity: send sym 1 then sym 3 back-to-back.
  - sym 1 samples: 0x00, 0x20, 0x40, 0x60.
  - sym 3 samples: 0x80, 0xC0, 0x00, 0x40.
  - No gap between symbols.
- Sine: phases 0x0000_0000, 0x4000_0000, 0xC000_0000 → da_data 128, 255, 1. Square: phase 0x8000_0000 → 0.
- Starvation: send one symbol with en=1 and no follow-up.
  - After the 4th sample, underrun pulses for 1 cycle.
  - busy falls and da_data=0x80.
  - Repeating with en=0 at the end of the symbol gives no underrun pulse.
- wave_sel changed mid-symbol → waveform unchanged until the next symbol load.
- sys_rst asserted mid-symbol → outputs return to reset values in the same cycle. After release, the first symbol restarts at phase 0.

Source files
------------

// File: rtl/mfsk_dds_mod_if.sv
// rtl/mfsk_dds_mod_if.sv - symbol handshake interface for mfsk_dds_mod
//
// Purpose: carries one BITS_PER_SYM-bit symbol per valid/ready handshake.
// Signals:
//   s_valid  source -> sink  symbol available
//   s_sym    source -> sink  symbol value
//   s_ready  sink -> source  symbol taken on an edge where s_valid && s_ready
// Modports: master (symbol source), slave (modulator side).

interface mfsk_dds_mod_if #(
    parameter int BITS_PER_SYM = 2
);
    logic                    s_valid;
    logic [BITS_PER_SYM-1:0] s_sym;
    logic                    s_ready;

    modport master (
        output s_valid,
        output s_sym,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_sym,
        output s_ready
    );
endinterface

// File: rtl/mfsk_dds_mod.sv
// rtl/mfsk_dds_mod.sv - phase-continuous M-ary FSK DDS modulator driving a parallel DAC
//
// Purpose: maps each accepted symbol to a tuning word (base + sym*step), runs a
// DDS phase accumulator for SYM_SAMPLES DAC samples per symbol and shapes the
// phase into sine-approx / triangle / square / sawtooth samples. DAC clock runs
// at i_sys_clk/2; samples update on the falling edge of o_da_clk.
// Ports:
//   i_sys_clk    sole clock
//   i_sys_rst    asynchronous active-high reset
//   i_en         enables symbol acceptance; low at end of symbol = clean stop
//   i_wave_sel   0 sine-approx, 1 triangle, 2 square, 3 sawtooth (latched at symbol load)
//   i_tone_base  tuning word for symbol 0
//   i_tone_step  tuning-word increment per symbol value
//   s_if         symbol handshake (slave modport)
//   o_da_data    DAC sample, offset binary
//   o_da_clk     DAC latch clock
//   o_busy       high while running symbols
//   o_underrun   one-cycle pulse when the symbol stream starves with i_en high

module mfsk_dds_mod #(
    parameter int DATA_W       = 8,
    parameter int PHASE_W      = 32,
    parameter int BITS_PER_SYM = 2,
    parameter int SYM_SAMPLES  = 1000
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  logic               i_en,
    input  logic [1:0]         i_wave_sel,
    input  logic [PHASE_W-1:0] i_tone_base,
    input  logic [PHASE_W-1:0] i_tone_step,
    mfsk_dds_mod_if.slave      s_if,
    output logic [DATA_W-1:0]  o_da_data,
    output logic               o_da_clk,
    output logic               o_busy,
    output logic               o_underrun
);

    localparam int                  CNT_W    = $clog2(SYM_SAMPLES);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(SYM_SAMPLES - 1);
    localparam logic [DATA_W-1:0]   MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]     X_MAX    = '1;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_TRI    = 2'd1;
    localparam logic [1:0] WAVE_SQUARE = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_t;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_tone_word;
    logic [1:0]          r_wave;
    logic [CNT_W-1:0]    r_samp_cnt;
    logic [DATA_W-1:0]   r_da_data;
    logic                r_underrun;

    logic                w_ready;
    logic                w_busy;
    logic                w_hs;
    logic                w_last;
    logic [PHASE_W-1:0]  w_sym_ext;
    logic [PHASE_W-1:0]  w_tone_word;
    logic [DATA_W-1:0]   w_wave;

    // Waveform shaping terms
    logic                w_h;
    logic [DATA_W-1:0]   w_r;
    logic [DATA_W:0]     w_x;
    logic [2*DATA_W+1:0] w_q;
    logic [DATA_W-1:0]   w_mag;
    logic                w_unused_q;

    // r_t is the sample-edge qualifier: an edge with r_t==1 is where da_clk falls.
    assign w_last    = (r_samp_cnt == LAST_CNT);
    assign w_hs      = s_if.s_valid && w_ready;
    assign w_sym_ext = PHASE_W'(s_if.s_sym);
    assign w_tone_word = i_tone_base + i_tone_step * w_sym_ext;

    assign w_h = r_phase[PHASE_W-1];
    assign w_r = r_phase[PHASE_W-2 -: DATA_W];
    assign w_x = r_phase[PHASE_W-2 -: DATA_W+1];
    // Parabolic half-wave: x*(2^(N+1)-1-x) peaks just under 2^(2N), so >> (N+1)
    // leaves a magnitude below 2^(N-1); the top product bit is always zero.
    assign w_q   = {{(DATA_W+1){1'b0}}, w_x} * {{(DATA_W+1){1'b0}}, X_MAX - w_x};
    assign w_mag = w_q[2*DATA_W:DATA_W+1];
    assign w_unused_q = ^{w_q[2*DATA_W+1], w_q[DATA_W:0]};

    always_comb begin
        w_wave = MIDSCALE;
        case (r_wave)
            WAVE_SINE:   w_wave = w_h ? (MIDSCALE - w_mag) : (MIDSCALE + w_mag);
            WAVE_TRI:    w_wave = w_h ? ~w_r : w_r;
            WAVE_SQUARE: w_wave = w_h ? '0 : '1;
            WAVE_SAW:    w_wave = r_phase[PHASE_W-1 -: DATA_W];
            default:     w_wave = MIDSCALE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. s_ready is held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = i_en && !i_sys_rst;
                if (s_if.s_valid && w_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy  = 1'b1;
                w_ready = r_t && w_last && !i_sys_rst;
                if (r_t && w_last && !s_if.s_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_t         <= 1'b0;
            r_phase     <= '0;
            r_tone_word <= '0;
            r_wave      <= WAVE_SAW;
            r_samp_cnt  <= '0;
            r_da_data   <= MIDSCALE;
            r_underrun  <= 1'b0;
        end else begin
            r_t        <= ~r_t;
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_phase   <= '0;
                    r_da_data <= MIDSCALE;
                    if (w_hs) begin
                        r_tone_word <= w_tone_word;
                        r_wave      <= i_wave_sel;
                        r_samp_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_t) begin
                        if (!w_last) begin
                            r_da_data  <= w_wave;
                            r_phase    <= r_phase + r_tone_word;
                            r_samp_cnt <= r_samp_cnt + 1'b1;
                        end else if (w_hs) begin
                            // Phase-continuous switch: this sample and this
                            // increment still belong to the outgoing tone.
                            r_da_data   <= w_wave;
                            r_phase     <= r_phase + r_tone_word;
                            r_tone_word <= w_tone_word;
                            r_wave      <= i_wave_sel;
                            r_samp_cnt  <= '0;
                        end else begin
                            r_phase    <= '0;
                            r_da_data  <= MIDSCALE;
                            r_samp_cnt <= '0;
                            r_underrun <= i_en;
                        end
                    end
                end
                default: begin
                    r_phase   <= '0;
                    r_da_data <= MIDSCALE;
                end
            endcase
        end
    end

    assign s_if.s_ready = w_ready;
    assign o_busy       = w_busy;
    assign o_da_clk     = r_t;
    assign o_da_data    = r_da_data;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_mfsk_dds_mod.sv
// tb/tb_mfsk_dds_mod.sv - directed self-checking bench for mfsk_dds_mod

module tb_mfsk_dds_mod;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  wave_sel = 2'd3;
    logic [31:0] tone_base = 32'h1000_0000;
    logic [31:0] tone_step = 32'h1000_0000;
    logic [7:0]  da_data;
    logic        da_clk;
    logic        busy;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    mfsk_dds_mod_if #(.BITS_PER_SYM(2)) sif();

    mfsk_dds_mod #(
        .DATA_W(8),
        .PHASE_W(32),
        .BITS_PER_SYM(2),
        .SYM_SAMPLES(4)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .i_en(en),
        .i_wave_sel(wave_sel),
        .i_tone_base(tone_base),
        .i_tone_step(tone_step),
        .s_if(sif),
        .o_da_data(da_data),
        .o_da_clk(da_clk),
        .o_busy(busy),
        .o_underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns the DAC value present after the next RUN sample edge (read on the following negedge).
    task automatic get_sample(output logic [7:0] d);
        d = 8'hxx;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (da_clk && busy) begin
                @(negedge clk);
                d = da_data;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL sample_timeout: got no sample edge, required one within 200 cycles");
    endtask

    task automatic drive_sym(input logic [1:0] sym, input logic [1:0] wave);
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_sym   = sym;
        wave_sel    = wave;
        for (int n = 0; n < 200; n++) begin
            if (sif.s_ready) begin
                @(posedge clk);
                #1;
                sif.s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: s_ready=0, required 1 within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: busy=%0b, required 0", busy);
    endtask

    task automatic test_reset();
        logic exp_clk;
        #1 rst = 1'b1;
        @(negedge clk);
        n_tests++; if (da_data !== 8'h80) begin n_fail++; $display("FAIL reset_da_data: got %h required 80", da_data); end
        n_tests++; if (da_clk !== 1'b0) begin n_fail++; $display("FAIL reset_da_clk: got %b required 0", da_clk); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        n_tests++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b required 0", sif.s_ready); end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_clk = (k % 2 == 1);
            n_tests++; if (da_clk !== exp_clk) begin n_fail++; $display("FAIL idle_toggle[%0d]: got %b required %b", k, da_clk, exp_clk); end
            n_tests++; if (da_data !== 8'h80) begin n_fail++; $display("FAIL idle_midscale[%0d]: got %h required 80", k, da_data); end
        end
        n_tests++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_en0: got %b required 0", sif.s_ready); end
        en = 1'b1;
        #1;
        n_tests++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_en1: got %b required 1", sif.s_ready); end
    endtask

    task automatic test_phase_continuity();
        logic [7:0] exp_d [12] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80, 8'h90, 8'hA0, 8'h80};
        logic [7:0] got [12];
        time        ts [12];
        int         gaps = 0;
        fork
            begin
                drive_sym(2'd1, 2'd3);
                drive_sym(2'd3, 2'd3);
                drive_sym(2'd0, 2'd3);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    get_sample(got[i]);
                    ts[i] = $time;
                end
            end
        join
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL continuity_sample[%0d]: got %h required %h", i, got[i], exp_d[i]); end
        end
        for (int i = 1; i < 12; i++) if (ts[i] - ts[i-1] != 20) gaps++;
        n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL continuity_gapfree: got %0d irregular sample intervals required 0", gaps); end
        wait_idle();
    endtask

    task automatic test_waveforms();
        logic [7:0] exp_d [12] = '{8'd128, 8'd255, 8'd128, 8'd1, 8'd128, 8'd255, 8'd128, 8'd1, 8'hFF, 8'hFF, 8'h00, 8'h80};
        logic [7:0] got [12];
        tone_base = 32'h4000_0000;
        tone_step = 32'h0;
        fork
            begin
                drive_sym(2'd0, 2'd0);
                drive_sym(2'd0, 2'd0);
                drive_sym(2'd0, 2'd2);
            end
            begin
                for (int i = 0; i < 12; i++) get_sample(got[i]);
            end
        join
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL sine_square_sample[%0d]: got %h required %h", i, got[i], exp_d[i]); end
        end
        tone_base = 32'h1000_0000;
        tone_step = 32'h1000_0000;
        wait_idle();
    endtask

    task automatic test_starvation();
        logic [7:0] exp_d [4] = '{8'h00, 8'h20, 8'h40, 8'h80};
        logic [7:0] got;
        en = 1'b1;
        drive_sym(2'd1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            get_sample(got);
            n_tests++; if (got !== exp_d[i]) begin n_fail++; $display("FAIL starve_sample[%0d]: got %h required %h", i, got, exp_d[i]); end
        end
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL starve_underrun: got %b required 1", underrun); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_busy: got %b required 0", busy); end
        @(negedge clk);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL starve_underrun_width: got %b required 0", underrun); end
        wait_idle();

        drive_sym(2'd1, 2'd3);
        en = 1'b0;
        for (int i = 0; i < 4; i++) get_sample(got);
        n_tests++; if (got !== 8'h80) begin n_fail++; $display("FAIL stop_midscale: got %h required 80", got); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL stop_underrun: got %b required 0", underrun); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b required 0", busy); end
        @(negedge clk);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL stop_underrun_late: got %b required 0", underrun); end
        en = 1'b1;
        wait_idle();
    endtask

    task automatic test_wave_sel_hold();
        logic [7:0] exp_d [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h80, 8'hA0, 8'hC0, 8'h80};
        logic [7:0] got [8];
        fork
            begin
                drive_sym(2'd1, 2'd1);
                repeat (3) @(negedge clk);
                wave_sel = 2'd3;
                drive_sym(2'd1, 2'd3);
            end
            begin
                for (int i = 0; i < 8; i++) get_sample(got[i]);
            end
        join
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL wave_hold_sample[%0d]: got %h required %h", i, got[i], exp_d[i]); end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_symbol();
        logic [7:0] exp_a [2] = '{8'h00, 8'h30};
        logic [7:0] exp_b [4] = '{8'h00, 8'h30, 8'h60, 8'h80};
        logic [7:0] got_a [2];
        logic [7:0] got_b [4];
        fork
            drive_sym(2'd2, 2'd3);
            begin
                for (int i = 0; i < 2; i++) get_sample(got_a[i]);
            end
        join
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL pre_reset_sample[%0d]: got %h required %h", i, got_a[i], exp_a[i]); end
        end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b required 1", busy); end
        rst = 1'b1;
        #1;
        n_tests++; if (da_data !== 8'h80) begin n_fail++; $display("FAIL midrst_da_data: got %h required 80", da_data); end
        n_tests++; if (da_clk !== 1'b0) begin n_fail++; $display("FAIL midrst_da_clk: got %b required 0", da_clk); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
        n_tests++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_s_ready: got %b required 0", sif.s_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            drive_sym(2'd2, 2'd3);
            begin
                for (int i = 0; i < 4; i++) get_sample(got_b[i]);
            end
        join
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL post_reset_sample[%0d]: got %h required %h", i, got_b[i], exp_b[i]); end
        end
        wait_idle();
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_sym   = 2'd0;
        test_reset();
        test_phase_continuity();
        test_waveforms();
        test_starvation();
        test_wave_sel_hold();
        test_reset_mid_symbol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
